muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Multi-cycle controller and datapath for the RV32M ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
//  Sits beside the single-cycle ALU in EX. When ID_EX decodes an M-extension op (funct7[0]=1), the
//  pipeline pulses start_i and holds on stall_o until valid_o; the result then goes to EX/MEM.
//  Iterative shift-add multiply and restoring divide; sign handling is done in wrapper states.
// PARAMETERS
//  XLEN  32  operand/result width; iteration count of RUN state
// PORTS
//  clk       in   1     clock, rising edge
//  rst       in   1     reset, asynchronous, active-high
//  start_i   in   1     request; sampled only in IDLE
//  flush_i   in   1     abort in-flight op (branch/exception flush)
//  funct3_i  in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  rs1_i     in   XLEN  operand A / dividend
//  rs2_i     in   XLEN  operand B / divisor
//  rd_i      in   5     destination tag, carried to rd_o
//  busy_o    out  1     state != IDLE
//  stall_o   out  1     freeze PC/IF/ID/EX regs
//  valid_o   out  1     one-cycle pulse: result_o/rd_o valid
//  result_o  out  XLEN  result, held until next accepted start
//  rd_o      out  5     tag of completed op
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; busy_o,stall_o,valid_o=0; result_o=0; rd_o=0; regs cleared.
//  States: IDLE -> PREP -> RUN -> FIX -> DONE -> IDLE.
//   IDLE: start_i=1 latches funct3/rs1/rs2/rd, goes PREP. Accept cycle = T.
//   PREP (T+1): latch |A|,|B| for signed operands (MULH: both; MULHSU: rs1 only; DIV/REM: both),
//    record result sign; zero counter. Special cases resolved here, skip RUN/FIX, go DONE:
//    - divisor==0: DIV/DIVU -> all ones; REM/REMU -> rs1.
//    - DIV only, rs1==1<<(XLEN-1) and rs2==all ones: DIV -> rs1; REM -> 0.
//   RUN: exactly XLEN cycles (counter 0..XLEN-1). MUL*: 2*XLEN-bit shift-add, one multiplier bit
//    per cycle. DIV*: restoring step, one quotient bit per cycle (shift rem, trial-subtract, set q bit).
//   FIX: negate 2*XLEN product if product sign set; quotient negated if signs differ; remainder
//    takes dividend sign. Select: MUL low half; MULH/MULHSU/MULHU high half; DIV* quotient; REM* remainder.
//   DONE: result_o registered, valid_o=1 for this cycle only, returns IDLE next edge.
//  Latency: normal op valid_o at T+XLEN+3 (T+35 for XLEN=32); special case at T+2.
//  stall_o = (IDLE & start_i) | PREP | RUN | FIX (combinational); low in DONE so the pipeline
//   advances in the same cycle it captures result_o.
//  start_i outside IDLE (including DONE) is ignored; no queueing. Back-to-back: next start accepted
//   earliest the cycle after DONE.
//  flush_i=1 in any non-IDLE state: next state IDLE, no valid_o, result_o/rd_o unchanged.
//   flush_i with start_i in IDLE: request dropped. flush_i in DONE: valid_o still pulses this cycle.
//  Arithmetic: all negation two's complement mod 2^XLEN (2^2XLEN for product); no exceptions raised.
// TESTING
//  DIV rs1=20 rs2=-3 (start at T) -> valid_o at T+35, result=0xFFFFFFFA; REM same operands -> 2.
//  DIVU rs1=0x1234 rs2=0 -> valid_o at T+2, result=0xFFFFFFFF; REMU -> 0x00001234.
//  DIV 0x80000000 / 0xFFFFFFFF -> valid T+2, result=0x80000000; REM -> 0x00000000.
//  MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF;
//   MULHU same -> 0xFFFFFFFE; MUL 7*-6 -> 0xFFFFFFD6; stall_o high T..T+34, low at T+35.
//  flush_i at T+10 of a DIV -> IDLE at T+11, no valid_o; start_i pulses during RUN ignored;
//   new start at T+12 completes at T+47 with its own rd_o.
//  rst asserted mid-RUN (asynchronous, between edges) -> outputs 0 immediately; after release,
//   fresh MULHU 3*5 -> result 0, MUL 3*5 -> 15.

Source files
------------

// File: rtl/muldiv_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// muldiv_sequencer : iterative RV32M multiply/divide unit beside the EX ALU
// Revision: 1.0
// ============================================================================
module muldiv_sequencer #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic            flush_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic [4:0]      rd_i,
   output logic            busy_o,
   output logic            stall_o,
   output logic            valid_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      rd_o
);

   localparam int              CW       = $clog2(XLEN);
   localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_RUN  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t            state_q;
   logic [2:0]        op_q;
   logic [XLEN-1:0]   a_q, b_q, m_q, hi_q, lo_q, result_q;
   logic [4:0]        tag_q, rd_q;
   logic              neg_q, rneg_q, valid_q;
   logic [CW-1:0]     cnt_q;

   logic              is_div, sgn_div, a_sgn, b_sgn, a_neg, b_neg;
   logic              div_by0, div_ovf;
   logic [XLEN-1:0]   a_mag, b_mag, special_res;
   logic [XLEN:0]     mul_sum, div_sh, div_diff;
   logic [XLEN-1:0]   hi_d, lo_d;
   logic [2*XLEN-1:0] prod, prod_fix;
   logic [XLEN-1:0]   q_fix, r_fix, fix_res;

   assign is_div  = op_q[2];
   assign sgn_div = is_div & ~op_q[0];
   assign a_sgn   = sgn_div | (~is_div & ((op_q[1:0] == 2'b01) | (op_q[1:0] == 2'b10)));
   assign b_sgn   = sgn_div | (~is_div & (op_q[1:0] == 2'b01));
   assign a_neg   = a_sgn & a_q[XLEN-1];
   assign b_neg   = b_sgn & b_q[XLEN-1];
   assign a_mag   = a_neg ? -a_q : a_q;
   assign b_mag   = b_neg ? -b_q : b_q;

   assign div_by0     = (b_q == '0);
   assign div_ovf     = sgn_div & (a_q == SMIN) & (b_q == '1);
   assign special_res = div_by0 ? (op_q[1] ? a_q : '1) : (op_q[1] ? '0 : a_q);

   // Multiply: hi accumulates, lo holds the remaining multiplier bits (shift right).
   // Divide: lo holds the dividend shifting out MSB-first while quotient bits shift in.
   assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
   assign div_sh   = {hi_q, lo_q[XLEN-1]};
   assign div_diff = div_sh - {1'b0, m_q};

   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (is_div) begin
         if (!div_diff[XLEN]) begin
            hi_d = div_diff[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b1};
         end else begin
            hi_d = div_sh[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
         end
      end else begin
         {hi_d, lo_d} = {mul_sum, lo_q[XLEN-1:1]};
      end
   end

   assign prod     = {hi_q, lo_q};
   assign prod_fix = neg_q ? -prod : prod;
   assign q_fix    = neg_q ? -lo_q : lo_q;
   assign r_fix    = rneg_q ? -hi_q : hi_q;

   always_comb begin
      fix_res = prod_fix[XLEN-1:0];
      if (is_div)
         fix_res = op_q[1] ? r_fix : q_fix;
      else if (op_q[1:0] != 2'b00)
         fix_res = prod_fix[2*XLEN-1:XLEN];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         m_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         result_q <= '0;
         tag_q    <= '0;
         rd_q     <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         valid_q  <= 1'b0;
         cnt_q    <= '0;
      end else if (flush_i && state_q != S_IDLE) begin
         state_q <= S_IDLE;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               valid_q <= 1'b0;
               if (start_i && !flush_i) begin
                  op_q    <= funct3_i;
                  a_q     <= rs1_i;
                  b_q     <= rs2_i;
                  tag_q   <= rd_i;
                  state_q <= S_PREP;
               end
            end
            S_PREP: begin
               cnt_q  <= '0;
               hi_q   <= '0;
               lo_q   <= a_mag;
               m_q    <= b_mag;
               neg_q  <= a_neg ^ b_neg;
               rneg_q <= a_neg;
               if (is_div && (div_by0 || div_ovf)) begin
                  result_q <= special_res;
                  rd_q     <= tag_q;
                  valid_q  <= 1'b1;
                  state_q  <= S_DONE;
               end else begin
                  state_q  <= S_RUN;
               end
            end
            S_RUN: begin
               hi_q  <= hi_d;
               lo_q  <= lo_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_LAST)
                  state_q <= S_FIX;
            end
            S_FIX: begin
               result_q <= fix_res;
               rd_q     <= tag_q;
               valid_q  <= 1'b1;
               state_q  <= S_DONE;
            end
            S_DONE: begin
               valid_q <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               valid_q <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Stall drops in DONE so the pipeline advances while capturing the result.
   assign stall_o  = ((state_q == S_IDLE) & start_i) | (state_q == S_PREP) |
                     (state_q == S_RUN) | (state_q == S_FIX);
   assign busy_o   = (state_q != S_IDLE);
   assign valid_o  = valid_q;
   assign result_o = result_q;
   assign rd_o     = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_muldiv_sequencer : randomized bench against an arithmetic RV32M model
// Revision: 1.0
// ============================================================================
module tb_muldiv_sequencer;

   localparam logic [31:0] SMIN = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i, flush_i;
   logic [2:0]  funct3_i;
   logic [31:0] rs1_i, rs2_i;
   logic [4:0]  rd_i;
   logic        busy_o, stall_o, valid_o;
   logic [31:0] result_o;
   logic [4:0]  rd_o;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] last_res;
   logic [4:0]  last_rd;

   muldiv_sequencer #(.XLEN(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .start_i  (start_i),
      .flush_i  (flush_i),
      .funct3_i (funct3_i),
      .rs1_i    (rs1_i),
      .rs2_i    (rs2_i),
      .rd_i     (rd_i),
      .busy_o   (busy_o),
      .stall_o  (stall_o),
      .valid_o  (valid_o),
      .result_o (result_o),
      .rd_o     (rd_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      p  = '0;
      case (op)
         3'd0: begin p = 64'(sa * sb); return p[31:0];  end
         3'd1: begin p = 64'(sa * sb); return p[63:32]; end
         3'd2: begin p = 64'(sa * ub); return p[63:32]; end
         3'd3: begin p = 64'(ua * ub); return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == SMIN && b == 32'hFFFF_FFFF) return a;
            p = 64'(sa / sb); return p[31:0];
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == SMIN && b == 32'hFFFF_FFFF) return 32'd0;
            p = 64'(sa % sb); return p[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op[2] && (b == 0 || (!op[0] && a == SMIN && b == 32'hFFFF_FFFF)))
         return 2;
      return 35;
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return SMIN;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 15));
         4:       return -32'($urandom_range(1, 15));
         default: return $urandom;
      endcase
   endfunction

   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      logic [31:0] exp_res;
      int          exp_lat;
      int          k;
      logic        stall_ok;
      exp_res = model(op, a, b);
      exp_lat = latency(op, a, b);
      @(negedge clk);
      funct3_i = op; rs1_i = a; rs2_i = b; rd_i = rd; start_i = 1'b1;
      #1 check("stall_accept", 32'(stall_o), 32'd1);
      @(posedge clk); #1;
      start_i  = 1'b0;
      k        = 1;
      stall_ok = 1'b1;
      while (!valid_o && k < 80) begin
         if (!stall_o) stall_ok = 1'b0;
         @(posedge clk); #1;
         k++;
      end
      check("stall_busy", 32'(stall_ok), 32'd1);
      check("latency", 32'(k), 32'(exp_lat));
      check("valid", 32'(valid_o), 32'd1);
      check("result", result_o, exp_res);
      check("rd", 32'(rd_o), 32'(rd));
      check("stall_done", 32'(stall_o), 32'd0);
      last_res = exp_res;
      last_rd  = rd;
      @(posedge clk); #1;
      check("valid_pulse", 32'(valid_o), 32'd0);
      check("idle_after", 32'(busy_o), 32'd0);
   endtask

   initial begin
      logic seen_valid;
      rst = 1'b1; start_i = 1'b0; flush_i = 1'b0;
      funct3_i = '0; rs1_i = '0; rs2_i = '0; rd_i = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_valid", 32'(valid_o), 32'd0);
      check("rst_stall", 32'(stall_o), 32'd0);
      check("rst_result", result_o, 32'd0);
      check("rst_rd", 32'(rd_o), 32'd0);
      @(negedge clk) rst = 1'b0;

      do_op(3'd4, 32'd20, -32'd3, 5'd1);
      do_op(3'd6, 32'd20, -32'd3, 5'd2);
      do_op(3'd5, 32'h1234, 32'd0, 5'd3);
      do_op(3'd7, 32'h1234, 32'd0, 5'd4);
      do_op(3'd4, SMIN, 32'hFFFF_FFFF, 5'd5);
      do_op(3'd6, SMIN, 32'hFFFF_FFFF, 5'd6);
      do_op(3'd1, SMIN, SMIN, 5'd7);
      do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8);
      do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
      do_op(3'd0, 32'd7, -32'd6, 5'd10);

      // Flush a DIV at T+10 after an ignored start pulse during RUN.
      @(negedge clk);
      funct3_i = 3'd4; rs1_i = 32'd1000; rs2_i = 32'd7; rd_i = 5'd20; start_i = 1'b1;
      @(posedge clk); #1;
      start_i    = 1'b0;
      seen_valid = 1'b0;
      for (int k = 1; k < 10; k++) begin
         if (k == 5) begin
            start_i = 1'b1; funct3_i = 3'd0; rd_i = 5'd21;
         end else begin
            start_i = 1'b0;
         end
         if (valid_o) seen_valid = 1'b1;
         @(posedge clk); #1;
      end
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      check("flush_idle", 32'(busy_o), 32'd0);
      check("flush_no_valid", 32'(seen_valid | valid_o), 32'd0);
      check("flush_rd_kept", 32'(rd_o), 32'(last_rd));
      check("flush_res_kept", result_o, last_res);
      do_op(3'd6, 32'd1000, 32'd7, 5'd22);

      for (int i = 0; i < 150; i++)
         do_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 5'($urandom_range(0, 31)));

      // Asynchronous reset between edges during RUN.
      @(negedge clk);
      funct3_i = 3'd3; rs1_i = 32'hDEAD_BEEF; rs2_i = 32'h1234_5678; rd_i = 5'd30; start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (8) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("arst_busy", 32'(busy_o), 32'd0);
      check("arst_valid", 32'(valid_o), 32'd0);
      check("arst_stall", 32'(stall_o), 32'd0);
      check("arst_result", result_o, 32'd0);
      check("arst_rd", 32'(rd_o), 32'd0);
      @(negedge clk) rst = 1'b0;
      do_op(3'd3, 32'd3, 32'd5, 5'd11);
      do_op(3'd0, 32'd3, 32'd5, 5'd12);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
